gcc_stereo_packer: RTL and testbench
====================================

Name: gcc_stereo_packer

Overview:
- Transmit-side front end for the GCC-PHAT core's 64-bit sample input stream.
- Accepts two independent 32-bit per-microphone AXI-Stream sample channels, deskews them with per-channel FIFOs, and emits one packed 64-bit word per time-aligned sample pair.
- Emits TLAST at analysis-frame boundaries and reports channel imbalance.
- Sits between the I2S/PDM decimation outputs and the core's stream_in port.

Parameters:
- SAMPLE_WIDTH, 32, width of each channel sample; output word is 2*SAMPLE_WIDTH.
- FIFO_DEPTH, 8, per-channel FIFO entries; power of 2, minimum 2.
- FRAME_LEN, 1024, output words per frame (TLAST period); minimum 2.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ch0_in_TDATA  in  SAMPLE_WIDTH  channel 0 sample.
- ch0_in_TVALID  in  1  channel 0 valid.
- ch0_in_TREADY  out  1  channel 0 ready.
- ch1_in_TDATA  in  SAMPLE_WIDTH  channel 1 sample.
- ch1_in_TVALID  in  1  channel 1 valid.
- ch1_in_TREADY  out  1  channel 1 ready.
- stream_out_TDATA  out  2*SAMPLE_WIDTH  packed word: {ch1[31:0], ch0[31:0]}; ch0 in the LSBs.
- stream_out_TVALID  out  1  output valid.
- stream_out_TREADY  in  1  downstream ready.
- stream_out_TLAST  out  1  last word of frame.
- frame_cnt  out  16  completed frames; wraps at 65535 -> 0.
- skew_err  out  1  sticky imbalance flag.
- skew_clr  in  1  synchronous clear of skew_err.

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, output register empty.
  - Outputs after reset: stream_out_TVALID=0, TDATA=0, TLAST=0, frame_cnt=0, skew_err=0, beat counter=0.
  - chN_in_TREADY=1, since the FIFOs are empty.
  - Reset mid-operation discards all buffered samples and the partial frame.
- Input side:
  - chN_in_TREADY = !fifoN_full. This is a registered-count comparison; it never depends combinationally on TVALID.
  - A write occurs on the edge where TVALID && TREADY.
  - The channels are independent; either may run ahead by up to FIFO_DEPTH samples.
- Pop condition: pop = fifo0_nonempty && fifo1_nonempty && (!stream_out_TVALID || stream_out_TREADY).
  - On pop, both FIFOs are read in the same cycle and the output register loads {fifo1_head, fifo0_head}.
  - TVALID is set when a pop occurs.
  - If there is no pop and stream_out_TREADY=1, TVALID is cleared.
- Full-FIFO write: when a FIFO is full, a simultaneous pop frees a slot, but TREADY stays low for that cycle (no write-through-full).
  - A write to an empty FIFO and a pop of the same FIFO cannot coincide, because pop requires non-empty.
- Latency: when both channels are accepted on edge E into empty FIFOs with an empty output register, TVALID asserts after edge E+1 carrying that pair.
- Throughput: 1 word/cycle sustained when both inputs stream and stream_out_TREADY=1.
- AXIS output rules: while TVALID=1 && TREADY=0, TDATA and TLAST hold stable and TVALID stays high.
- TLAST / beat counter:
  - beat_cnt (log2 FRAME_LEN bits, wide enough for FRAME_LEN-1) tags each loaded word.
  - TLAST=1 on the word loaded when beat_cnt==FRAME_LEN-1.
  - beat_cnt increments on each pop and wraps FRAME_LEN-1 -> 0.
- frame_cnt increments on the output handshake (TVALID && TREADY) of a TLAST word.
- skew_err:
  - Set on any cycle where one FIFO is full and the other is empty (one channel stalled a full FIFO ahead).
  - skew_clr=1 clears it; if the set condition holds in the same cycle, set wins.
  - Data handling is unaffected: the leading channel is simply backpressured.
- Ordering: samples are never dropped, duplicated, or reordered within a channel. Pairing is strictly by arrival index per channel.

Test Plan:
- Lockstep streaming: both channels send ch0=0x1000+i, ch1=0x2000+i for i=0..2047, TREADY=1.
  - Required: output words are 0x00002000_00001000 + i*(2^32+1) in order at 1/cycle.
  - TLAST on i=1023 and i=2047; frame_cnt ends at 2.
- Skew: ch0 sends 8 samples while ch1 is idle.
  - Required: ch0_in_TREADY drops after the 8th write; skew_err=1; no output.
  - Then ch1 sends 8 samples: 8 correctly paired words appear, and ch0_in_TREADY returns to 1.
- Backpressure: stream_out_TREADY held 0 for 20 cycles mid-stream.
  - Required: TDATA/TVALID/TLAST stable throughout; both FIFOs fill and both chN_in_TREADY=0.
  - After release: no lost or duplicated words (sequence check).
- Latency: single pair (ch0=0xA5A5A5A5, ch1=0x5A5A5A5A) accepted on edge E.
  - Required: TVALID=1 with TDATA=0x5A5A5A5A_A5A5A5A5 after edge E+1.
- skew_clr: skew_clr=1 while the imbalance persists leaves skew_err=1. After rebalancing, skew_clr=1 gives skew_err=0 on the next cycle.
- Reset mid-frame: assert ap_rst_n=0 after 500 words.
  - Required: TVALID=0 and frame_cnt=0 immediately (async).
  - After release, the next TLAST occurs on the 1024th subsequent word.

Source files
------------

// File: rtl/gcc_stereo_packer.sv
// Stereo front end for the GCC-PHAT core: deskews two per-microphone sample streams
// in small FIFOs and emits one {ch1, ch0} word per aligned pair, with frame TLAST.
module gcc_stereo_packer #(
   parameter int SAMPLE_WIDTH = 32,
   parameter int FIFO_DEPTH   = 8,
   parameter int FRAME_LEN    = 1024
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic [SAMPLE_WIDTH-1:0]   ch0_in_TDATA,
   input  logic                      ch0_in_TVALID,
   output logic                      ch0_in_TREADY,
   input  logic [SAMPLE_WIDTH-1:0]   ch1_in_TDATA,
   input  logic                      ch1_in_TVALID,
   output logic                      ch1_in_TREADY,
   output logic [2*SAMPLE_WIDTH-1:0] stream_out_TDATA,
   output logic                      stream_out_TVALID,
   input  logic                      stream_out_TREADY,
   output logic                      stream_out_TLAST,
   output logic [15:0]               frame_cnt,
   output logic                      skew_err,
   input  logic                      skew_clr
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

   logic [SAMPLE_WIDTH-1:0]   w_in_data [2];
   logic [SAMPLE_WIDTH-1:0]   w_head    [2];
   logic [1:0]                w_in_valid;
   logic [1:0]                w_full;
   logic [1:0]                w_empty;
   logic [1:0]                w_wr;
   logic                      w_pop;
   logic                      w_skew_set;

   logic [2*SAMPLE_WIDTH-1:0] r_tdata;
   logic                      r_tvalid;
   logic                      r_tlast;
   logic [BEAT_W-1:0]         r_beat;
   logic [15:0]               r_frame_cnt;
   logic                      r_skew_err;

   assign w_in_data[0]  = ch0_in_TDATA;
   assign w_in_data[1]  = ch1_in_TDATA;
   assign w_in_valid[0] = ch0_in_TVALID;
   assign w_in_valid[1] = ch1_in_TVALID;

   // A full FIFO refuses writes even if the same edge pops it; no write-through.
   assign w_wr  = w_in_valid & ~w_full;
   assign w_pop = !w_empty[0] && !w_empty[1] && (!r_tvalid || stream_out_TREADY);

   for (genvar c = 0; c < 2; c++) begin : g_fifo
      logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]        r_wptr;
      logic [PTR_W-1:0]        r_rptr;
      logic [CNT_W-1:0]        r_cnt;

      assign w_full[c]  = (r_cnt == FULL_CNT);
      assign w_empty[c] = (r_cnt == {CNT_W{1'b0}});
      assign w_head[c]  = r_mem[r_rptr];

      // Sample storage; contents are don't-care until the count says otherwise.
      always_ff @(posedge ap_clk) begin
         if (w_wr[c]) begin
            r_mem[r_wptr] <= w_in_data[c];
         end
      end

      // Pointer and occupancy bookkeeping.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            r_wptr <= {PTR_W{1'b0}};
            r_rptr <= {PTR_W{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
         end else begin
            if (w_wr[c]) begin
               r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr[c], w_pop})
               2'b10:   r_cnt <= r_cnt + CNT_W'(1);
               2'b01:   r_cnt <= r_cnt - CNT_W'(1);
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

   // Output skid register with per-frame beat tagging.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_tvalid <= 1'b0;
         r_tdata  <= {(2*SAMPLE_WIDTH){1'b0}};
         r_tlast  <= 1'b0;
         r_beat   <= {BEAT_W{1'b0}};
      end else if (w_pop) begin
         r_tvalid <= 1'b1;
         r_tdata  <= {w_head[1], w_head[0]};
         r_tlast  <= (r_beat == LAST_BEAT);
         r_beat   <= (r_beat == LAST_BEAT) ? {BEAT_W{1'b0}} : r_beat + BEAT_W'(1);
      end else if (stream_out_TREADY) begin
         r_tvalid <= 1'b0;
      end else begin
         r_tvalid <= r_tvalid;
      end
   end

   // Completed-frame counter, stepped when a TLAST word is accepted downstream.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_frame_cnt <= 16'd0;
      end else if (r_tvalid && stream_out_TREADY && r_tlast) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
         r_frame_cnt <= r_frame_cnt;
      end
   end

   assign w_skew_set = (w_full[0] && w_empty[1]) || (w_full[1] && w_empty[0]);

   // Sticky imbalance flag; a live imbalance beats a clear request.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_skew_err <= 1'b0;
      end else if (w_skew_set) begin
         r_skew_err <= 1'b1;
      end else if (skew_clr) begin
         r_skew_err <= 1'b0;
      end else begin
         r_skew_err <= r_skew_err;
      end
   end

   assign ch0_in_TREADY     = !w_full[0];
   assign ch1_in_TREADY     = !w_full[1];
   assign stream_out_TDATA  = r_tdata;
   assign stream_out_TVALID = r_tvalid;
   assign stream_out_TLAST  = r_tlast;
   assign frame_cnt         = r_frame_cnt;
   assign skew_err          = r_skew_err;

endmodule

// File: tb/tb_gcc_stereo_packer.sv
// Bench for gcc_stereo_packer: directed and randomized traffic, checked against a
// model that pairs accepted samples by per-channel arrival index.
`timescale 1ns/1ps
module tb_gcc_stereo_packer;
   localparam int SW = 32;
   localparam int FD = 8;
   localparam int FL = 1024;

   logic            ap_clk = 1'b0;
   logic            ap_rst_n;
   logic [SW-1:0]   ch0_in_TDATA, ch1_in_TDATA;
   logic            ch0_in_TVALID, ch1_in_TVALID;
   logic            ch0_in_TREADY, ch1_in_TREADY;
   logic [2*SW-1:0] stream_out_TDATA;
   logic            stream_out_TVALID, stream_out_TREADY, stream_out_TLAST;
   logic [15:0]     frame_cnt;
   logic            skew_err, skew_clr;

   int n_pass  = 0;
   int n_total = 0;

   // model state: samples accepted per channel, words handed downstream
   logic [SW-1:0]   acc0 [$];
   logic [SW-1:0]   acc1 [$];
   logic [2*SW-1:0] obs_d [$];
   logic            obs_l [$];

   always #5 ap_clk = ~ap_clk;

   gcc_stereo_packer #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(FD), .FRAME_LEN(FL)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .ch0_in_TDATA(ch0_in_TDATA), .ch0_in_TVALID(ch0_in_TVALID), .ch0_in_TREADY(ch0_in_TREADY),
      .ch1_in_TDATA(ch1_in_TDATA), .ch1_in_TVALID(ch1_in_TVALID), .ch1_in_TREADY(ch1_in_TREADY),
      .stream_out_TDATA(stream_out_TDATA), .stream_out_TVALID(stream_out_TVALID),
      .stream_out_TREADY(stream_out_TREADY), .stream_out_TLAST(stream_out_TLAST),
      .frame_cnt(frame_cnt), .skew_err(skew_err), .skew_clr(skew_clr)
   );

   // One clock of stimulus; records what the upcoming edge will accept/emit.
   task automatic cyc(input logic v0, input logic [SW-1:0] d0,
                      input logic v1, input logic [SW-1:0] d1, input logic ordy);
      ch0_in_TVALID = v0;  ch0_in_TDATA = d0;
      ch1_in_TVALID = v1;  ch1_in_TDATA = d1;
      stream_out_TREADY = ordy;
      @(negedge ap_clk);
      if (v0 && ch0_in_TREADY) acc0.push_back(d0);
      if (v1 && ch1_in_TREADY) acc1.push_back(d1);
      if (stream_out_TVALID && ordy) begin
         obs_d.push_back(stream_out_TDATA);
         obs_l.push_back(stream_out_TLAST);
      end
      @(posedge ap_clk);
      #1;
   endtask

   task automatic clear_model();
      acc0.delete(); acc1.delete(); obs_d.delete(); obs_l.delete();
   endtask

   task automatic do_reset();
      ap_rst_n = 1'b0;
      ch0_in_TVALID = 1'b0; ch1_in_TVALID = 1'b0;
      ch0_in_TDATA = '0; ch1_in_TDATA = '0;
      stream_out_TREADY = 1'b0; skew_clr = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      clear_model();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic drain();
      repeat (FD + 4) cyc(1'b0, '0, 1'b0, '0, 1'b1);
   endtask

   function automatic int n_pairs();
      return (acc0.size() < acc1.size()) ? acc0.size() : acc1.size();
   endfunction

   task automatic test_reset();
      do_reset();
      n_total++;
      if (stream_out_TVALID !== 1'b0 || stream_out_TDATA !== 64'd0 || stream_out_TLAST !== 1'b0)
         $display("FAIL reset_out: valid=%b data=%h last=%b, want 0/0/0",
                  stream_out_TVALID, stream_out_TDATA, stream_out_TLAST);
      else n_pass++;
      n_total++;
      if (frame_cnt !== 16'd0 || skew_err !== 1'b0)
         $display("FAIL reset_status: frame_cnt=%0d skew_err=%b, want 0/0", frame_cnt, skew_err);
      else n_pass++;
      n_total++;
      if (ch0_in_TREADY !== 1'b1 || ch1_in_TREADY !== 1'b1)
         $display("FAIL reset_ready: got %b%b, want 11", ch0_in_TREADY, ch1_in_TREADY);
      else n_pass++;
   endtask

   task automatic test_lockstep();
      logic [2*SW-1:0] e;
      do_reset();
      for (int i = 0; i < 2048; i++) cyc(1'b1, 32'h1000 + i, 1'b1, 32'h2000 + i, 1'b1);
      repeat (2) cyc(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++;
      if (obs_d.size() != 2048) $display("FAIL lockstep_rate: %0d words, want 2048", obs_d.size());
      else n_pass++;
      for (int k = 0; k < obs_d.size() && k < 2048; k++) begin
         e = 64'h00002000_00001000 + 64'(k) * 64'h1_0000_0001;
         n_total++;
         if (obs_d[k] !== e || obs_l[k] !== ((k % FL) == FL - 1))
            $display("FAIL lockstep_word[%0d]: got %h last=%b, want %h last=%b",
                     k, obs_d[k], obs_l[k], e, ((k % FL) == FL - 1));
         else n_pass++;
      end
      n_total++;
      if (frame_cnt !== 16'd2) $display("FAIL lockstep_frames: got %0d, want 2", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_skew();
      int np;
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, 1'b0, '0, 1'b1);
      n_total++;
      if (ch0_in_TREADY !== 1'b0 || ch1_in_TREADY !== 1'b1)
         $display("FAIL skew_ready: got ch0=%b ch1=%b, want 0/1", ch0_in_TREADY, ch1_in_TREADY);
      else n_pass++;
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++;
      if (skew_err !== 1'b1 || obs_d.size() != 0)
         $display("FAIL skew_flag: skew_err=%b words=%0d, want 1/0", skew_err, obs_d.size());
      else n_pass++;
      skew_clr = 1'b1;
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      skew_clr = 1'b0;
      n_total++;
      if (skew_err !== 1'b1) $display("FAIL skew_clr_held: got %b, want 1", skew_err);
      else n_pass++;
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, $urandom, 1'b1);
      drain();
      n_total++;
      if (ch0_in_TREADY !== 1'b1) $display("FAIL skew_ready_back: got %b, want 1", ch0_in_TREADY);
      else n_pass++;
      skew_clr = 1'b1;
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      skew_clr = 1'b0;
      n_total++;
      if (skew_err !== 1'b0) $display("FAIL skew_clr: got %b, want 0", skew_err);
      else n_pass++;
      np = n_pairs();
      n_total++;
      if (obs_d.size() != 8 || np != 8) $display("FAIL skew_count: got %0d words, want 8", obs_d.size());
      else n_pass++;
      for (int k = 0; k < obs_d.size() && k < np; k++) begin
         n_total++;
         if (obs_d[k] !== {acc1[k], acc0[k]} || obs_l[k] !== 1'b0)
            $display("FAIL skew_word[%0d]: got %h, want %h", k, obs_d[k], {acc1[k], acc0[k]});
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [2*SW-1:0] snap_d;
      logic            snap_l, snap_v, stable;
      int              np;
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b1, $urandom, 1'b1);
      snap_d = stream_out_TDATA; snap_l = stream_out_TLAST; snap_v = stream_out_TVALID;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, $urandom, 1'b1, $urandom, 1'b0);
         if (stream_out_TDATA !== snap_d || stream_out_TVALID !== 1'b1 || stream_out_TLAST !== snap_l)
            stable = 1'b0;
      end
      n_total++;
      if (snap_v !== 1'b1 || stable !== 1'b1)
         $display("FAIL bp_stable: valid_at_stall=%b stable=%b, want 1/1", snap_v, stable);
      else n_pass++;
      n_total++;
      if (ch0_in_TREADY !== 1'b0 || ch1_in_TREADY !== 1'b0)
         $display("FAIL bp_full: ready=%b%b, want 00", ch0_in_TREADY, ch1_in_TREADY);
      else n_pass++;
      for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b1, $urandom, 1'b1);
      drain();
      np = n_pairs();
      n_total++;
      if (obs_d.size() != np) $display("FAIL bp_count: got %0d words, want %0d", obs_d.size(), np);
      else n_pass++;
      for (int k = 0; k < obs_d.size() && k < np; k++) begin
         n_total++;
         if (obs_d[k] !== {acc1[k], acc0[k]})
            $display("FAIL bp_word[%0d]: got %h, want %h", k, obs_d[k], {acc1[k], acc0[k]});
         else n_pass++;
      end
   endtask

   task automatic test_latency();
      do_reset();
      cyc(1'b1, 32'hA5A5A5A5, 1'b1, 32'h5A5A5A5A, 1'b1);
      n_total++;
      if (stream_out_TVALID !== 1'b0 || acc0.size() != 1 || acc1.size() != 1)
         $display("FAIL lat_early: valid=%b accepted=%0d/%0d, want 0 1/1",
                  stream_out_TVALID, acc0.size(), acc1.size());
      else n_pass++;
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++;
      if (stream_out_TVALID !== 1'b1 || stream_out_TDATA !== 64'h5A5A5A5A_A5A5A5A5)
         $display("FAIL lat_word: valid=%b data=%h, want 1 5a5a5a5aa5a5a5a5",
                  stream_out_TVALID, stream_out_TDATA);
      else n_pass++;
   endtask

   task automatic test_random();
      int np;
      do_reset();
      for (int i = 0; i < 2500; i++)
         cyc($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3) != 0);
      drain();
      np = n_pairs();
      n_total++;
      if (obs_d.size() != np) $display("FAIL rand_count: got %0d words, want %0d", obs_d.size(), np);
      else n_pass++;
      for (int k = 0; k < obs_d.size() && k < np; k++) begin
         n_total++;
         if (obs_d[k] !== {acc1[k], acc0[k]} || obs_l[k] !== ((k % FL) == FL - 1))
            $display("FAIL rand_word[%0d]: got %h last=%b, want %h last=%b",
                     k, obs_d[k], obs_l[k], {acc1[k], acc0[k]}, ((k % FL) == FL - 1));
         else n_pass++;
      end
      n_total++;
      if (frame_cnt !== 16'(obs_d.size() / FL))
         $display("FAIL rand_frames: got %0d, want %0d", frame_cnt, obs_d.size() / FL);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int np;
      do_reset();
      for (int i = 0; i < 600 && obs_d.size() < 500; i++) cyc(1'b1, $urandom, 1'b1, $urandom, 1'b1);
      n_total++;
      if (obs_d.size() != 500) $display("FAIL mid_reach: got %0d words, want 500", obs_d.size());
      else n_pass++;
      ap_rst_n = 1'b0;
      #1;
      n_total++;
      if (stream_out_TVALID !== 1'b0 || frame_cnt !== 16'd0 || ch0_in_TREADY !== 1'b1)
         $display("FAIL mid_async: valid=%b frame_cnt=%0d ready0=%b, want 0/0/1",
                  stream_out_TVALID, frame_cnt, ch0_in_TREADY);
      else n_pass++;
      ch0_in_TVALID = 1'b0; ch1_in_TVALID = 1'b0;
      #2;
      ap_rst_n = 1'b1;
      clear_model();
      for (int i = 0; i < FL + 2; i++) cyc(1'b1, $urandom, 1'b1, $urandom, 1'b1);
      np = n_pairs();
      n_total++;
      if (obs_d.size() != FL) $display("FAIL mid_count: got %0d words, want %0d", obs_d.size(), FL);
      else n_pass++;
      for (int k = 0; k < obs_d.size() && k < np; k++) begin
         n_total++;
         if (obs_d[k] !== {acc1[k], acc0[k]} || obs_l[k] !== ((k % FL) == FL - 1))
            $display("FAIL mid_word[%0d]: got %h last=%b, want %h last=%b",
                     k, obs_d[k], obs_l[k], {acc1[k], acc0[k]}, ((k % FL) == FL - 1));
         else n_pass++;
      end
      n_total++;
      if (frame_cnt !== 16'd1) $display("FAIL mid_frames: got %0d, want 1", frame_cnt);
      else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit, %0d/%0d checks done", n_pass, n_total);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lockstep();
      test_skew();
      test_backpressure();
      test_latency();
      test_random();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
